mux8_rr_arbiter: RTL and testbench

MUX8_RR_ARBITER -- requirements
Module: mux8_rr_arbiter

---
 rtl/mux8_rr_arbiter_pkg.sv | 20 ++
 rtl/mux8_rr_arbiter_if.sv | 31 +++
 rtl/mux8_rr_arbiter_rr_pick8.sv | 38 +++
 rtl/mux8_rr_arbiter.sv | 83 ++++++++
 tb/tb_mux8_rr_arbiter.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared definitions for the 8-source round-robin arbiter / 8:1 mux.
//   NUM_SRC : number of requesting sources
//   SEL_W   : width of a source index
//   state_t : arbiter FSM state (IDLE, OWNED)
//   onehot  : index -> one-hot grant vector
package mux8_rr_arbiter_pkg;

    localparam int NUM_SRC = 8;
    localparam int SEL_W   = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    function automatic logic [NUM_SRC-1:0] onehot(input logic [SEL_W-1:0] idx);
        return NUM_SRC'(1) << idx;
    endfunction

endpackage

// File: rtl/mux8_rr_arbiter_if.sv
// Bus between the eight sources and the arbiter.
//   req[7:0]     : request per source (bit i = source i)
//   done         : owner releases its grant
//   data_in[7:0] : data bit per source
//   grant[7:0]   : one-hot grant, zero when idle
//   sel[2:0]     : current or last owner index
//   out          : shared mux output
//   busy         : a grant is held
// The slave modport is the arbiter side; master is the sources' side.
interface mux8_rr_arbiter_if;
    import mux8_rr_arbiter_pkg::*;

    logic [NUM_SRC-1:0] req;
    logic               done;
    logic [NUM_SRC-1:0] data_in;
    logic [NUM_SRC-1:0] grant;
    logic [SEL_W-1:0]   sel;
    logic               out;
    logic               busy;

    modport slave (
        input  req, done, data_in,
        output grant, sel, out, busy
    );

    modport master (
        output req, done, data_in,
        input  grant, sel, out, busy
    );

endinterface

// File: rtl/mux8_rr_arbiter_rr_pick8.sv
// Combinational round-robin picker.
//   req[7:0]   : request vector
//   ptr[2:0]   : index where the search starts (highest priority)
//   winner[2:0]: first set request at or above ptr, wrapping 7 -> 0
//   valid      : at least one request is set (winner meaningful)
module rr_pick8
    import mux8_rr_arbiter_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [SEL_W-1:0]   winner,
    output logic               valid
);

    // rot[k] is the request of the source k positions after ptr; the
    // index arithmetic wraps naturally because it is SEL_W bits wide.
    logic [SEL_W-1:0]   idx [NUM_SRC];
    logic [NUM_SRC-1:0] rot;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_rot
            assign idx[gi] = ptr + SEL_W'(gi);
            assign rot[gi] = req[idx[gi]];
        end
    endgenerate

    // Walk from the far end down so the lowest offset from ptr wins.
    always_comb begin
        winner = ptr;
        valid  = |req;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (rot[k]) begin
                winner = idx[k];
            end
        end
    end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter for eight sources driving a shared 8:1 mux.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : mux8_rr_arbiter_if.slave (req, done, data_in -> grant, sel, out, busy)
// Parameter MAX_HOLD (1..255): longest a single grant may be held, in cycles.
// A grant appears one cycle after the request is seen in IDLE. It is dropped
// on done, on the owner withdrawing its request, or when the hold limit is
// reached. One IDLE cycle always separates two grants.
module mux8_rr_arbiter
    import mux8_rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    mux8_rr_arbiter_if.slave bus
);

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t             state_reg;
    logic [SEL_W-1:0]   sel_reg;
    logic [SEL_W-1:0]   ptr_reg;
    logic [7:0]         hold_cnt_reg;
    logic [NUM_SRC-1:0] grant_reg;

    logic [SEL_W-1:0]   pick_idx;
    logic               pick_valid;
    logic               release_now;

    rr_pick8 u_pick (
        .req    (bus.req),
        .ptr    (ptr_reg),
        .winner (pick_idx),
        .valid  (pick_valid)
    );

    // done and the hold limit may coincide; either way it is one release.
    assign release_now = bus.done
                       | ~bus.req[sel_reg]
                       | (hold_cnt_reg == HOLD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            sel_reg      <= '0;
            ptr_reg      <= '0;
            hold_cnt_reg <= '0;
            grant_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pick_valid) begin
                        sel_reg      <= pick_idx;
                        grant_reg    <= onehot(pick_idx);
                        hold_cnt_reg <= '0;
                        state_reg    <= OWNED;
                    end
                end
                OWNED: begin
                    if (release_now) begin
                        state_reg <= IDLE;
                        grant_reg <= '0;
                        ptr_reg   <= sel_reg + SEL_W'(1);
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + 8'd1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    grant_reg <= '0;
                end
            endcase
        end
    end

    assign bus.grant = grant_reg;
    assign bus.sel   = sel_reg;
    assign bus.busy  = (state_reg == OWNED);
    // Shared 8:1 mux, forced low whenever nobody owns the bus.
    assign bus.out   = bus.busy ? bus.data_in[sel_reg] : 1'b0;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter (MAX_HOLD = 4).
module tb_mux8_rr_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    mux8_rr_arbiter_if bus ();

    mux8_rr_arbiter #(.MAX_HOLD(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_idle(input string tag, input logic [2:0] exp_sel);
        check_eq({tag, ".grant"}, 32'(bus.grant), 32'h0);
        check_eq({tag, ".busy"},  32'(bus.busy),  32'h0);
        check_eq({tag, ".out"},   32'(bus.out),   32'h0);
        check_eq({tag, ".sel"},   32'(bus.sel),   32'(exp_sel));
    endtask

    task automatic expect_grant(input string tag, input logic [2:0] idx);
        logic [7:0] oh;
        oh = 8'h01 << idx;
        check_eq({tag, ".grant"}, 32'(bus.grant), 32'(oh));
        check_eq({tag, ".busy"},  32'(bus.busy),  32'h1);
        check_eq({tag, ".sel"},   32'(bus.sel),   32'(idx));
    endtask

    initial begin
        rst         = 1'b1;
        bus.req     = 8'h00;
        bus.done    = 1'b0;
        bus.data_in = 8'h00;
        tick();
        tick();
        expect_idle("reset", 3'd0);
        rst = 1'b0;

        // No requests: stays idle
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_idle($sformatf("noreq%0d", i), 3'd0);
        end

        // req=81, done 3 cycles into each grant: 0 -> 7 -> 0
        bus.req = 8'h81;
        tick();
        expect_grant("rr_g0", 3'd0);
        tick();
        tick();
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        expect_idle("rr_idle0", 3'd0);
        tick();
        expect_grant("rr_g7", 3'd7);
        tick();
        tick();
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        expect_idle("rr_idle1", 3'd7);
        tick();
        expect_grant("rr_g0b", 3'd0);
        tick();
        tick();
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        bus.req  = 8'h00;
        expect_idle("rr_idle2", 3'd0);

        // Hold limit (4 cycles) on source 2, with mux output checks
        bus.req = 8'h04;
        tick();
        expect_grant("hold_c1", 3'd2);
        bus.data_in = 8'h04;
        #1;
        check_eq("out_hi", 32'(bus.out), 32'h1);
        bus.data_in = 8'h00;
        #1;
        check_eq("out_lo", 32'(bus.out), 32'h0);
        for (int i = 2; i <= 4; i++) begin
            tick();
            expect_grant($sformatf("hold_c%0d", i), 3'd2);
        end
        tick();
        bus.data_in = 8'h04;
        #1;
        expect_idle("hold_rel", 3'd2);
        tick();
        expect_grant("hold_regrant", 3'd2);
        bus.data_in = 8'h00;
        bus.req     = 8'h00;
        tick();
        expect_idle("withdraw2", 3'd2);

        // Source 5 withdraws; next grant from ptr=6
        bus.req = 8'h20;
        tick();
        expect_grant("g5", 3'd5);
        bus.req = 8'h41;
        tick();
        expect_idle("rel5", 3'd5);
        tick();
        expect_grant("g6_after5", 3'd6);
        bus.req = 8'h43;
        tick();
        expect_grant("g6_ignore_others", 3'd6);
        bus.req = 8'h00;
        tick();
        expect_idle("rel6", 3'd6);
        bus.done = 1'b1;
        tick();
        expect_idle("done_in_idle", 3'd6);
        bus.done = 1'b0;

        // Reset in the 2nd OWNED cycle of source 3
        bus.req = 8'h08;
        tick();
        expect_grant("g3_c1", 3'd3);
        tick();
        expect_grant("g3_c2", 3'd3);
        rst = 1'b1;
        tick();
        expect_idle("rst_owned", 3'd0);
        rst = 1'b0;
        tick();
        expect_grant("g3_after_rst", 3'd3);

        // Reset must return ptr to 0: req=81 then goes to source 0
        rst     = 1'b1;
        bus.req = 8'h81;
        tick();
        expect_idle("rst2", 3'd0);
        rst = 1'b0;
        tick();
        expect_grant("ptr0_g0", 3'd0);

        // done coinciding with the hold limit: single release, ptr=1
        tick();
        tick();
        tick();
        expect_grant("lim_c4", 3'd0);
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        expect_idle("lim_done_rel", 3'd0);
        tick();
        expect_grant("lim_next7", 3'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
